// File: rtl/fp_to_fixed_serial.sv
// rtl/fp_to_fixed_serial.sv - serial 13-bit float to signed fixed-point converter
// Optional saturation with overflow flag when FP2FIX_SAT_EN is defined; wrap-around otherwise.
module fp_to_fixed_serial #(
  parameter int OUT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [3:0]       in_exp,
  input  logic [7:0]       in_frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   result;
  logic               result_ovf;

`ifdef FP2FIX_SAT_EN
  logic               sticky_q, sticky_d;
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  // Sticky already holds any bit that reached the sign position, so it is the overflow flag.
  always_comb begin
    result_ovf = sticky_q;
    if (sticky_q) begin
      result = sign_q ? SAT_NEG : SAT_POS;
    end else begin
      result = sign_q ? (~acc_q + {{(OUT_W-1){1'b0}}, 1'b1}) : acc_q;
    end
  end
`else
  always_comb begin
    result_ovf = 1'b0;
    result     = sign_q ? (~acc_q + {{(OUT_W-1){1'b0}}, 1'b1}) : acc_q;
  end
`endif

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
`ifdef FP2FIX_SAT_EN
    sticky_d  = sticky_q;
`endif
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          acc_d   = {{(OUT_W-8){1'b0}}, in_frac};
          cnt_d   = in_exp;
`ifdef FP2FIX_SAT_EN
          sticky_d = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 4'd0) begin
          acc_d = {acc_q[OUT_W-2:0], 1'b0};
          cnt_d = cnt_q - 4'd1;
`ifdef FP2FIX_SAT_EN
          // Catch bits leaving the word and bits entering the sign position.
          sticky_d = sticky_q | acc_q[OUT_W-1] | acc_q[OUT_W-2];
`endif
        end else begin
          data_d  = result;
          ovf_d   = result_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= 4'd0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
`ifdef FP2FIX_SAT_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
`ifdef FP2FIX_SAT_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign out_data = data_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_fp_to_fixed_serial.sv
// tb/tb_fp_to_fixed_serial.sv - scoreboard bench driving OUT_W=24 and OUT_W=16 instances in lockstep
module tb_fp_to_fixed_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sign, out_ready;
  logic [3:0]  in_exp;
  logic [7:0]  in_frac;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_data;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_data16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       s;
    logic [3:0] e;
    logic [7:0] f;
    int         acc_cyc;
  } item_t;
  item_t sb[$];
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp_to_fixed_serial #(.OUT_W(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  fp_to_fixed_serial #(.OUT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_ovf(out_ovf16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model_data(input int w, input logic s,
                                             input logic [3:0] e, input logic [7:0] f);
    longint mag, maxv, r;
    mag  = longint'(f) << e;
    maxv = (64'sd1 <<< (w - 1)) - 1;
    r    = s ? -mag : mag;
`ifdef FP2FIX_SAT_EN
    if (mag > maxv) r = s ? -maxv : maxv;
`endif
    r = r & ((64'sd1 <<< w) - 1);
    return r[31:0];
  endfunction

  function automatic logic [31:0] model_ovf(input int w, input logic [3:0] e, input logic [7:0] f);
    longint mag, maxv;
    mag  = longint'(f) << e;
    maxv = (64'sd1 <<< (w - 1)) - 1;
`ifdef FP2FIX_SAT_EN
    return (mag > maxv) ? 32'd1 : 32'd0;
`else
    return (mag > maxv) ? 32'd0 : 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      check("lockstep_valid", {31'd0, out_valid16}, {31'd0, out_valid});
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("spurious_valid", 32'd1, 32'd0);
        else check("latency", cyc - sb[0].acc_cyc, 32'(sb[0].e) + 1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("empty_scoreboard", 32'd1, 32'd0);
        end else begin
          item_t it;
          it = sb.pop_front();
          check("data24", {8'd0, out_data}, model_data(24, it.s, it.e, it.f));
          check("ovf24", {31'd0, out_ovf}, model_ovf(24, it.e, it.f));
          check("data16", {16'd0, out_data16}, model_data(16, it.s, it.e, it.f));
          check("ovf16", {31'd0, out_ovf16}, model_ovf(16, it.e, it.f));
        end
      end
      if (in_valid && in_ready) begin
        item_t n;
        n.s = in_sign; n.e = in_exp; n.f = in_frac; n.acc_cyc = cyc + 1;
        sb.push_back(n);
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic s, input logic [3:0] e, input logic [7:0] f);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 4'd0; in_frac = 8'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_out_data16", {16'd0, out_data16}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(1'b0, 4'd3, 8'hC0); in_valid = 1'b0; drain();
    send(1'b1, 4'd0, 8'h80); in_valid = 1'b0; drain();
    send(1'b1, 4'd9, 8'h00); in_valid = 1'b0; drain();

    out_ready = 1'b0;
    send(1'b0, 4'd15, 8'hFF); in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check("hold_valid_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {8'd0, out_data}, 32'h7F8000);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);

    send(1'b0, 4'd8, 8'hFF); in_valid = 1'b0; drain();
    send(1'b1, 4'd8, 8'hFF); in_valid = 1'b0; drain();

    send(1'b0, 4'd10, 8'h55); in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_data", {8'd0, out_data}, 32'd0);
    check("abort_out_ovf", {31'd0, out_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      check("abort_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(1'b0, 4'd1, 8'h01); in_valid = 1'b0; drain();

    send(1'b0, 4'd2, 8'h01);
    send(1'b0, 4'd0, 8'h03);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      in_valid = 1'b0;
      drain();
    end
    send(1'b1, 4'd15, 8'hFF); in_valid = 1'b0; drain();
    send(1'b0, 4'd7, 8'h00); in_valid = 1'b0; drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_to_fixed_serial.md
Name: fp_to_fixed_serial

Overview:
- Converts one value in the team's 13-bit float format (sign, 4-bit exponent, 8-bit fraction) into a signed two's-complement fixed-point integer.
- Sits downstream of the floating-point adder and feeds integer consumers such as the LIDAR range accumulators.
- Uses an iterative one-bit-per-cycle shifter behind valid/ready handshakes on both sides.
- Value definition: result = (sign ? -1 : +1) × frac × 2^exp.

Parameters:
- OUT_W, 24: output width in bits, signed two's complement. Legal range 10..32. The default holds the full format range without overflow.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input value present.
- in_ready  out  1  block can accept a value.
- in_sign  in  1  input sign.
- in_exp  in  4  input exponent (0..15).
- in_frac  in  8  input fraction (integer magnitude).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  OUT_W  signed fixed-point result.
- out_ovf  out  1  overflow flag, valid while out_valid=1.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0; out_data=0; out_ovf=0.
  - internal accumulator, count and sticky registers cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch sign, load accumulator = zero-extended frac, set cnt=exp, clear sticky, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - If cnt≠0: accumulator <<= 1; sticky |= bit shifted out of the magnitude field or into the sign bit (bit OUT_W-1); cnt -= 1.
  - If cnt=0: form the result, register out_data and out_ovf, go to DONE.
- Latency: out_valid rises exp+1 cycles after the accepting edge (exp=0 gives 1 cycle; exp=15 gives 16 cycles).
- DONE:
  - out_valid=1; out_data and out_ovf held stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE; out_valid low next cycle.
  - in_ready rises on that same edge. A new input is not accepted in the handshake cycle, so throughput is at most one value per exp+3 cycles.
- Result forming:
  - Magnitude is in bits OUT_W-2..0.
  - If sign=1, out_data is the two's-complement negation of the magnitude.
  - frac=0 always yields out_data=0 (no negative zero), regardless of sign and exp, with out_ovf=0.
- Overflow: magnitude > 2^(OUT_W-1)-1. Handling depends on FP2FIX_SAT_EN (see Optional Feature).
- in_* inputs are ignored outside IDLE. They need be stable only on the accepting edge.
- out_ready is ignored outside DONE.
- Reset mid-SHIFT or mid-DONE aborts immediately. The pending result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro: FP2FIX_SAT_EN.
- Defined:
  - On overflow, out_data saturates to +(2^(OUT_W-1)-1) for sign=0 or -(2^(OUT_W-1)-1) for sign=1 (symmetric), and out_ovf=1.
  - The sticky logic is instantiated.
- Undefined:
  - No sticky logic; out_ovf is tied to 0.
  - out_data is the low OUT_W bits of the signed exact result (wrap-around).

Test Plan:
- OUT_W=24, sign=0, exp=3, frac=0xC0, out_ready=1 -> out_data=0x000600, out_valid 4 cycles after accept, out_ovf=0.
- sign=1, exp=0, frac=0x80 -> out_data=0xFFFF80 (-128) after 1 cycle; then sign=1, exp=9, frac=0x00 -> out_data=0x000000.
- sign=0, exp=15, frac=0xFF -> out_data=0x7F8000 after 16 cycles, out_ovf=0. Hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; release -> IDLE next cycle.
- OUT_W=16, sign=0, exp=8, frac=0xFF:
  - with FP2FIX_SAT_EN -> out_data=0x7FFF, out_ovf=1; with sign=1 -> out_data=0x8001, out_ovf=1.
  - without the macro -> out_data=0xFF00, out_ovf=0.
- Accept exp=10, frac=0x55; assert rst_n=0 after 4 SHIFT cycles -> outputs at reset values immediately, no out_valid pulse. After release, sign=0, exp=1, frac=0x01 -> out_data=0x000002.
- Back-to-back: in_valid held high with two values (exp=2, frac=0x01; exp=0, frac=0x03), out_ready=1 -> results 0x000004 then 0x000003, each input accepted only while in IDLE.
